// File: rtl/inert_spi_mstr.sv
// 16-bit SPI mode-3 master for the inertial sensor: shifts cmd out MSB-first while capturing MISO.
// Optional SPI_BUSY_ERR_EN adds a busy_err pulse for wrt requests that arrive mid-transaction.
module inert_spi_mstr #(
  parameter int DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
`ifdef SPI_BUSY_ERR_EN
  ,
  output logic        busy_err
`endif
);

  typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} state_t;

  // Front porch starts three quarters into a period so the first fall comes after 2^(DIV_W-2) clks.
  localparam logic [DIV_W-1:0] CNT_FRONT = DIV_W'(3 << (DIV_W - 2));
  localparam logic [DIV_W-1:0] CNT_SMPL  = DIV_W'((1 << (DIV_W - 1)) - 1);
  localparam logic [DIV_W-1:0] CNT_ALL   = '1;
  localparam logic [DIV_W-1:0] CNT_ONE   = DIV_W'(1);

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [15:0]      shft;
  logic             smpl;
  logic [4:0]       bit_cnt;

  assign SCLK = (state == IDLE) ? 1'b1 : cnt[DIV_W-1];
  assign MOSI = shft[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shft    <= '0;
      smpl    <= 1'b0;
      bit_cnt <= '0;
      done    <= 1'b0;
      SS_n    <= 1'b1;
      rd_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wrt) begin
            shft    <= cmd;
            done    <= 1'b0;
            SS_n    <= 1'b0;
            cnt     <= CNT_FRONT;
            bit_cnt <= '0;
            state   <= FRONT;
          end
        end
        FRONT: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_ALL) state <= SHIFT;
        end
        SHIFT: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_SMPL) begin
            smpl    <= MISO;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) state <= BACK;
          end
          if (cnt == CNT_ALL) shft <= {shft[14:0], smpl};
        end
        BACK: begin
          // SCLK stays high here; only the last sample still needs shifting in.
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_ALL) begin
            shft    <= {shft[14:0], smpl};
            rd_data <= {shft[14:0], smpl};
            done    <= 1'b1;
            SS_n    <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_BUSY_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_err <= 1'b0;
    else        busy_err <= wrt && (state != IDLE);
  end
`endif

endmodule

// File: tb/tb_inert_spi_mstr.sv
// Directed bench for inert_spi_mstr: table of transactions against loopback or a mode-3 slave model.
module tb_inert_spi_mstr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
`ifdef SPI_BUSY_ERR_EN
  logic        busy_err;
`endif

  inert_spi_mstr #(.DIV_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .cmd     (cmd),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
`ifdef SPI_BUSY_ERR_EN
    ,
    .busy_err(busy_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] tx;
    bit          lpbk;
    bit          busy;
    logic [15:0] exp;
  } vec_t;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // slave model / bus monitor state
  bit          lpbk   = 1'b1;
  logic [15:0] cur_tx = '0;
  logic [15:0] s_tx   = '0;
  logic [15:0] s_rx   = '0;
  logic        sclk_q = 1'b1;
  logic        ss_q   = 1'b1;
  int          rises  = 0;
  int          t_first = 0;
  int          t_second = 0;
  int          idle_bad = 0;
  int          berr_cnt = 0;

  assign MISO = lpbk ? MOSI : s_tx[15];

  always @(posedge clk) cyc <= cyc + 1;

  // Mode-3 slave: samples MOSI on SCLK rise, presents next MISO bit after it.
  always @(negedge clk) begin
    sclk_q <= SCLK;
    ss_q   <= SS_n;
    if (SS_n && !SCLK) idle_bad <= idle_bad + 1;
    if (ss_q && !SS_n) begin
      s_tx  <= cur_tx;
      s_rx  <= '0;
      rises <= 0;
    end else if (!SS_n && !sclk_q && SCLK) begin
      s_rx  <= {s_rx[14:0], MOSI};
      s_tx  <= {s_tx[14:0], 1'b0};
      rises <= rises + 1;
      if (rises == 0) t_first  <= cyc;
      if (rises == 1) t_second <= cyc;
    end
`ifdef SPI_BUSY_ERR_EN
    if (busy_err) berr_cnt <= berr_cnt + 1;
`endif
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  // Called at a negedge; returns at the negedge where done is first seen high.
  task automatic run_vec(input vec_t v);
    int n;
    int low;
    int berr0;
    cur_tx = v.tx;
    lpbk   = v.lpbk;
    cmd    = v.cmd;
    wrt    = 1'b1;
    berr0  = berr_cnt;
    @(posedge clk);
    @(negedge clk);
    wrt = 1'b0;
    cmd = ~v.cmd;
    chk("done_clear", done, 1'b0);
    low = SS_n ? 0 : 1;
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!SS_n) low++;
      if (v.busy && n == 99) begin
        wrt = 1'b1;
        cmd = 16'hFFFF;
      end
      if (v.busy && n == 100) begin
        wrt = 1'b0;
`ifdef SPI_BUSY_ERR_EN
        chk("busy_err_at_100", busy_err, 1'b1);
`endif
      end
    end
    chk("latency", n, 520);
    chk("ss_low_clks", low, 520);
    chk("sclk_rises", rises, 16);
    chk("sclk_period", t_second - t_first, 32);
    chk("rd_data", rd_data, v.exp);
    chk("slave_rx", s_rx, v.cmd);
    chk("done_high", done, 1'b1);
`ifdef SPI_BUSY_ERR_EN
    chk("busy_err_pulses", berr_cnt - berr0, v.busy ? 1 : 0);
`endif
  endtask

  vec_t tbl[7];

  initial begin
    vec_t rv;
    int lows;
    logic [15:0] rd_hold;

    tbl[0] = '{cmd: 16'hA5C3, tx: 16'h0000, lpbk: 1'b1, busy: 1'b0, exp: 16'hA5C3};
    tbl[1] = '{cmd: 16'hA200, tx: 16'h005A, lpbk: 1'b0, busy: 1'b0, exp: 16'h005A};
    tbl[2] = '{cmd: 16'h0D02, tx: 16'h3C01, lpbk: 1'b0, busy: 1'b0, exp: 16'h3C01};
    tbl[3] = '{cmd: 16'h1053, tx: 16'h8000, lpbk: 1'b0, busy: 1'b0, exp: 16'h8000};
    tbl[4] = '{cmd: 16'h1150, tx: 16'h00FF, lpbk: 1'b0, busy: 1'b0, exp: 16'h00FF};
    tbl[5] = '{cmd: 16'h1460, tx: 16'h7E81, lpbk: 1'b0, busy: 1'b0, exp: 16'h7E81};
    tbl[6] = '{cmd: 16'h6B17, tx: 16'h0000, lpbk: 1'b1, busy: 1'b1, exp: 16'h6B17};

    rst_n = 1'b0;
    wrt   = 1'b0;
    cmd   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", SS_n, 1'b1);
    chk("rst_sclk", SCLK, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_data", rd_data, 16'h0000);
    chk("rst_mosi", MOSI, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Each vector starts on the cycle after done, so the table also runs back-to-back.
    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Re-pulsed wrt must not launch a second transaction.
    rd_hold = rd_data;
    lows = 0;
    repeat (40) begin
      @(negedge clk);
      if (!SS_n) lows++;
    end
    chk("no_second_xfer", lows, 0);
    chk("rd_data_stable", rd_data, rd_hold);
    chk("done_held", done, 1'b1);

    // Reset in the middle of a transaction.
    lpbk = 1'b1;
    cmd  = 16'h5555;
    wrt  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wrt = 1'b0;
    repeat (299) @(negedge clk);
    chk("mid_ss_low", SS_n, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ss_n", SS_n, 1'b1);
    chk("mid_rst_sclk", SCLK, 1'b1);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_rd_data", rd_data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rv = '{cmd: 16'h9C3E, tx: 16'h0000, lpbk: 1'b1, busy: 1'b0, exp: 16'h9C3E};
    run_vec(rv);

    chk("sclk_high_when_idle", idle_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
